perf_counter_bank: RTL and testbench

- Parametrised event-counter bank for the pipelined CPU; generalises the fixed 16-bit cycle, conditional-jump, unconditional-jump and taken-conditional-jump counters.
- NUM_CH independent channels with a halt-driven freeze FSM, wrap or saturate overflow mode, sticky overflow flags and a selectable 32-bit readout for the display mux.
- Sits beside the npc/BHT logic; event pulses come from the EX stage, halt comes from the syscall halt detector.

---
 rtl/perf_counter_bank.sv | 147 ++++++++++++++
 tb/tb_perf_counter_bank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//   Event-counter bank for the pipelined CPU. NUM_CH independent counters
//   count single-cycle event pulses from the EX stage. A halt level freezes
//   counting until the bank is cleared. Overflow either wraps or saturates,
//   and in both modes it sets a sticky per-channel flag. One counter is
//   presented, zero-extended to 32 bits, for the display mux.
//
//   Optional feature macro: PERF_SNAPSHOT_EN
//     defined   : shadow bank, snap_req and auto-snapshot on halt entry;
//                 rd_src selects live (0) or shadow (1)
//     undefined : no shadow bank; snap_req and rd_src are ignored
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   clr       synchronous clear of counters, shadows, flags and FSM
//   halt      CPU halted (level)
//   ev        per-channel event pulse
//   snap_req  copy live counters to shadow (single cycle)
//   rd_src    readout source: 0 live, 1 shadow
//   sel       readout channel select
//   rd_data   selected counter, zero-extended
//   ovf       sticky per-channel overflow flags
//   frozen    FSM is in FROZEN
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_RUN    | counting enabled while halt is low
// ST_FROZEN | counting disabled; left only through clr
module perf_counter_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int SAT       = 0,
  parameter int SEL_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              halt,
  input  logic [NUM_CH-1:0] ev,
  input  logic              snap_req,
  input  logic              rd_src,
  input  logic [SEL_W-1:0]  sel,
  output logic [31:0]       rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic              frozen
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  live_q [NUM_CH];
  logic [CNT_WIDTH-1:0]  live_d [NUM_CH];
  logic [NUM_CH-1:0]     ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  rd_word;

  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = ST_RUN;
      ovf_d   = '0;
      for (int i = 0; i < NUM_CH; i++) live_d[i] = '0;
    end else begin
      if (halt) state_d = ST_FROZEN;
      // halt gates the count in its first cycle, before the FSM has moved
      for (int i = 0; i < NUM_CH; i++) begin
        if (state_q == ST_RUN && !halt && ev[i]) begin
          if (live_q[i] == {CNT_WIDTH{1'b1}}) begin
            ovf_d[i]  = 1'b1;
            live_d[i] = (SAT != 0) ? {CNT_WIDTH{1'b1}} : '0;
          end else begin
            live_d[i] = live_q[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      ovf_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) live_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      live_q  <= live_d;
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_WIDTH-1:0] shadow_q [NUM_CH];
  logic [CNT_WIDTH-1:0] shadow_d [NUM_CH];
  logic                 snap_trig;

  // pre-edge live values are captured, so a same-cycle increment is excluded
  assign snap_trig = snap_req || (state_q == ST_RUN && halt);

  always_comb begin
    shadow_d = shadow_q;
    if (clr) begin
      for (int i = 0; i < NUM_CH; i++) shadow_d[i] = '0;
    end else if (snap_trig) begin
      shadow_d = live_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(sel) == i) rd_word = rd_src ? shadow_q[i] : live_q[i];
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = &{1'b0, snap_req, rd_src};

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(sel) == i) rd_word = live_q[i];
    end
  end
`endif

  always_comb begin
    rd_data                = '0;
    rd_data[CNT_WIDTH-1:0] = rd_word;
  end

  assign ovf    = ovf_q;
  assign frozen = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_perf_counter_bank.sv
`timescale 1ns/1ps
module tb_perf_counter_bank;

  localparam int DUT_M = 0;   // 16-bit, wrap
  localparam int DUT_W = 1;   // 4-bit, wrap
  localparam int DUT_S = 2;   // 4-bit, saturate
  localparam int K_RD  = 0;
  localparam int K_OVF = 1;
  localparam int K_FRZ = 2;

`ifdef PERF_SNAPSHOT_EN
  localparam logic [31:0] SNAP_EXP = 32'd4;
`else
  localparam logic [31:0] SNAP_EXP = 32'd8;
`endif

  logic        clk, rst, clr, halt, snap_req, rd_src;
  logic [3:0]  ev;
  logic [2:0]  sel;
  logic [31:0] rd_m, rd_w, rd_s;
  logic [3:0]  ovf_m, ovf_w, ovf_s;
  logic        frz_m, frz_w, frz_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    int          dut;
    int          kind;
    logic        src;
    logic [2:0]  sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  perf_counter_bank #(.NUM_CH(4), .CNT_WIDTH(16), .SAT(0), .SEL_W(3)) u_dut_m (
    .clk(clk), .rst(rst), .clr(clr), .halt(halt), .ev(ev), .snap_req(snap_req),
    .rd_src(rd_src), .sel(sel), .rd_data(rd_m), .ovf(ovf_m), .frozen(frz_m));

  perf_counter_bank #(.NUM_CH(4), .CNT_WIDTH(4), .SAT(0), .SEL_W(3)) u_dut_w (
    .clk(clk), .rst(rst), .clr(clr), .halt(halt), .ev(ev), .snap_req(snap_req),
    .rd_src(rd_src), .sel(sel), .rd_data(rd_w), .ovf(ovf_w), .frozen(frz_w));

  perf_counter_bank #(.NUM_CH(4), .CNT_WIDTH(4), .SAT(1), .SEL_W(3)) u_dut_s (
    .clk(clk), .rst(rst), .clr(clr), .halt(halt), .ev(ev), .snap_req(snap_req),
    .rd_src(rd_src), .sel(sel), .rd_data(rd_s), .ovf(ovf_s), .frozen(frz_s));

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int dut, input int kind);
    logic [31:0] r;
    r = '0;
    case (kind)
      K_RD:  r = (dut == DUT_M) ? rd_m : (dut == DUT_W) ? rd_w : rd_s;
      K_OVF: r = {28'd0, (dut == DUT_M) ? ovf_m : (dut == DUT_W) ? ovf_w : ovf_s};
      default: r = {31'd0, (dut == DUT_M) ? frz_m : (dut == DUT_W) ? frz_w : frz_s};
    endcase
    return r;
  endfunction

  task automatic push_rd(input string tag, input int dut, input logic src,
                         input logic [2:0] s, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.dut = dut; x.kind = K_RD; x.src = src; x.sel = s; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic push_flag(input string tag, input int dut, input int kind,
                           input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.dut = dut; x.kind = kind; x.src = 1'b0; x.sel = 3'd0; x.exp = e;
    sb.push_back(x);
  endtask

  // readout is combinational, so sel/rd_src are stepped between clock edges
  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      sel    = x.sel;
      rd_src = x.src;
      #1;
      chk(x.tag, observe(x.dut, x.kind), x.exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; halt = 1'b0; ev = 4'b0000;
    snap_req = 1'b0; rd_src = 1'b0; sel = 3'd0;

    // reset state
    cycles(2);
    push_rd("rst_rd", DUT_M, 1'b0, 3'd0, 32'd0);
    push_flag("rst_ovf", DUT_M, K_OVF, 32'd0);
    push_flag("rst_frz", DUT_M, K_FRZ, 32'd0);
    drain();
    rst = 1'b1;
    cycles(1);

    // basic count and out-of-range select
    ev = 4'b0001;
    cycles(10);
    ev = 4'b0000;
    push_rd("cnt_ch0", DUT_M, 1'b0, 3'd0, 32'h0000000A);
    push_rd("cnt_ch1", DUT_M, 1'b0, 3'd1, 32'd0);
    push_rd("cnt_sel5", DUT_M, 1'b0, 3'd5, 32'd0);
    push_rd("cnt_sel4", DUT_M, 1'b0, 3'd4, 32'd0);
    drain();

    // parallel channels
    clr_pulse();
    ev = 4'b1111; cycles(3);
    ev = 4'b0101; cycles(2);
    ev = 4'b0000;
    push_rd("par_ch0", DUT_M, 1'b0, 3'd0, 32'd5);
    push_rd("par_ch1", DUT_M, 1'b0, 3'd1, 32'd3);
    push_rd("par_ch2", DUT_M, 1'b0, 3'd2, 32'd5);
    push_rd("par_ch3", DUT_M, 1'b0, 3'd3, 32'd3);
    drain();

    // wrap / saturate on a 4-bit counter, 17 events on channel 2
    clr_pulse();
    ev = 4'b0100; cycles(17);
    ev = 4'b0000;
    push_rd("wide_ch2", DUT_M, 1'b0, 3'd2, 32'd17);
    push_flag("wide_ovf", DUT_M, K_OVF, 32'd0);
    push_rd("wrap_ch2", DUT_W, 1'b0, 3'd2, 32'd1);
    push_flag("wrap_ovf", DUT_W, K_OVF, 32'h4);
    push_rd("sat_ch2", DUT_S, 1'b0, 3'd2, 32'd15);
    push_flag("sat_ovf", DUT_S, K_OVF, 32'h4);
    drain();

    // halt freeze; ovf from the previous step is left set on purpose
    ev = 4'b0001; cycles(7);
    halt = 1'b1; ev = 4'b1111; cycles(1);
    push_flag("halt_frz_first", DUT_M, K_FRZ, 32'd1);
    drain();
    cycles(5);
    halt = 1'b0; cycles(2);
    ev = 4'b0000;
    push_rd("halt_ch0", DUT_M, 1'b0, 3'd0, 32'd7);
    push_rd("halt_ch1", DUT_M, 1'b0, 3'd1, 32'd0);
    push_flag("halt_frz_after", DUT_M, K_FRZ, 32'd1);
    push_rd("halt_shadow_ch0", DUT_M, 1'b1, 3'd0, 32'd7);
    push_flag("sticky_ovf", DUT_W, K_OVF, 32'h4);
    drain();

    // clear wins over events and snapshot while frozen
    clr = 1'b1; ev = 4'b1111; snap_req = 1'b1;
    cycles(1);
    clr = 1'b0; ev = 4'b0000; snap_req = 1'b0;
    push_rd("clr_ch0", DUT_M, 1'b0, 3'd0, 32'd0);
    push_rd("clr_ch2", DUT_M, 1'b0, 3'd2, 32'd0);
    push_rd("clr_shadow_ch0", DUT_M, 1'b1, 3'd0, 32'd0);
    push_flag("clr_ovf_w", DUT_W, K_OVF, 32'd0);
    push_flag("clr_ovf_s", DUT_S, K_OVF, 32'd0);
    push_flag("clr_frz", DUT_M, K_FRZ, 32'd0);
    drain();
    ev = 4'b0010; cycles(1);
    ev = 4'b0000;
    push_rd("post_clr_ch1", DUT_M, 1'b0, 3'd1, 32'd1);
    drain();

    // snapshot vs live
    clr_pulse();
    ev = 4'b0010; cycles(4);
    snap_req = 1'b1; cycles(1);
    snap_req = 1'b0; cycles(3);
    ev = 4'b0000;
    push_rd("snap_shadow", DUT_M, 1'b1, 3'd1, SNAP_EXP);
    push_rd("snap_live", DUT_M, 1'b0, 3'd1, 32'd8);
    drain();

    // clr with halt held: RUN for one cycle, then FROZEN again
    halt = 1'b1; cycles(1);
    push_flag("hc_frz_a", DUT_M, K_FRZ, 32'd1);
    drain();
    clr = 1'b1; cycles(1);
    clr = 1'b0;
    push_flag("hc_frz_b", DUT_M, K_FRZ, 32'd0);
    drain();
    cycles(1);
    push_flag("hc_frz_c", DUT_M, K_FRZ, 32'd1);
    drain();
    halt = 1'b0;
    clr_pulse();

    // asynchronous reset mid-count
    ev = 4'b1111; cycles(17);
    push_rd("pre_rst_ch0", DUT_M, 1'b0, 3'd0, 32'd17);
    push_flag("pre_rst_ovf", DUT_W, K_OVF, 32'hF);
    drain();
    #20;
    rst = 1'b0;
    #1;
    push_rd("arst_ch0", DUT_M, 1'b0, 3'd0, 32'd0);
    push_rd("arst_ch3", DUT_M, 1'b0, 3'd3, 32'd0);
    push_flag("arst_ovf_w", DUT_W, K_OVF, 32'd0);
    push_flag("arst_ovf_s", DUT_S, K_OVF, 32'd0);
    push_flag("arst_frz", DUT_M, K_FRZ, 32'd0);
    drain();
    ev = 4'b0000;
    cycles(2);
    rst = 1'b1;
    cycles(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
